mac_boot_sequencer: RTL and testbench



---
 rtl/mac_boot_sequencer_pkg.sv | 14 +
 rtl/mac_boot_sequencer_sync2.sv | 22 ++
 rtl/mac_boot_sequencer.sv | 112 +++++++++++
 tb/tb_mac_boot_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_boot_sequencer_pkg.sv
// Shared state encoding and counter widths for the MacPlus boot/reset sequencer.
package mac_boot_pkg;

  typedef enum logic [2:0] {
    LOCK    = 3'd0,
    MEMINIT = 3'd1,
    ROM     = 3'd2,
    HOLD    = 3'd3,
    RUN     = 3'd4
  } boot_state_t;

  localparam int DLY_W = 20;

endpackage

// File: rtl/mac_boot_sequencer_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Latency: two clk edges; no flow control.
module mac_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mac_boot_sequencer.sv
// Power-on / download / user-reset sequencer producing the MacPlus core and CPU resets.
// Reset outputs lag the state by one clk_sys cycle; no flow control, inputs are levels.
module mac_boot_sequencer
  import mac_boot_pkg::*;
#(
  parameter logic [DLY_W-1:0] DELAY      = 20'hFFFFF,
  parameter int               RESET_BITS = 16,
  parameter int               CPU_LAG    = 16
) (
  input  logic       clk_sys,
  input  logic       RESET_N,
  input  logic       pll_locked,
  input  logic       sdram_ready,
  input  logic       rom_download,
  input  logic       rom_valid,
  input  logic       user_reset,
  output logic       sdram_init,
  output logic       core_reset,
  output logic       cpu_reset_n,
  output logic [2:0] boot_state,
  output logic       busy
);

  localparam logic [7:0] LAG = 8'(CPU_LAG);

  boot_state_t           state;
  logic                  locked_s;
  logic                  ur_q;
  logic                  ureq;
  logic [RESET_BITS-1:0] lock_cnt;
  logic [DLY_W-1:0]      dly_cnt;
  logic [7:0]            lag_cnt;

  mac_sync2 u_lock_sync (
    .clk   (clk_sys),
    .rst_n (RESET_N),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign ureq       = user_reset & ~ur_q;
  assign boot_state = state;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= LOCK;
      lock_cnt    <= '0;
      dly_cnt     <= '0;
      lag_cnt     <= '0;
      ur_q        <= 1'b0;
      sdram_init  <= 1'b0;
      core_reset  <= 1'b1;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b1;
    end else begin
      ur_q        <= user_reset;
      core_reset  <= (state != RUN);
      busy        <= (state != RUN);
      cpu_reset_n <= (state == RUN) && (lag_cnt == LAG);
      sdram_init  <= 1'b0;
      // Counters only survive while their own state holds; any exit clears them.
      lock_cnt    <= '0;
      lag_cnt     <= '0;

      case (state)
        LOCK: begin
          if (locked_s) begin
            if (&lock_cnt) begin
              state      <= MEMINIT;
              sdram_init <= 1'b1;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
        end

        MEMINIT: begin
          if (!locked_s)        state <= LOCK;
          else if (sdram_ready) state <= ROM;
        end

        ROM: begin
          if (!locked_s) begin
            state <= LOCK;
          end else if (!rom_download && rom_valid) begin
            state   <= HOLD;
            dly_cnt <= DELAY;
          end
        end

        HOLD, RUN: begin
          if (!locked_s) begin
            state <= LOCK;
          end else if (rom_download) begin
            state <= ROM;
          end else if (ureq) begin
            state   <= HOLD;
            dly_cnt <= DELAY;
          end else if (state == HOLD) begin
            if (dly_cnt == '0) state <= RUN;
            else               dly_cnt <= dly_cnt - 1'b1;
          end else begin
            lag_cnt <= (lag_cnt == LAG) ? lag_cnt : lag_cnt + 1'b1;
          end
        end

        default: state <= LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_boot_sequencer.sv
// Directed test-plan scenarios followed by random stimulus, all checked against a cycle reference model.
module tb_mac_boot_sequencer;
  import mac_boot_pkg::*;

  localparam int DLY = 16;
  localparam int RB  = 4;
  localparam int LAG = 4;

  logic       clk_sys = 1'b0;
  logic       RESET_N = 1'b0;
  logic       pll_locked = 1'b0, sdram_ready = 1'b0, rom_download = 1'b0;
  logic       rom_valid = 1'b0, user_reset = 1'b0;
  logic       sdram_init, core_reset, cpu_reset_n, busy;
  logic [2:0] boot_state;

  int n_cmp = 0;
  int n_bad = 0;
  int n_init = 0;
  int n, k, entries, prev_bs;

  always #5 clk_sys = ~clk_sys;

  mac_boot_sequencer #(
    .DELAY      (20'd16),
    .RESET_BITS (RB),
    .CPU_LAG    (LAG)
  ) dut (
    .clk_sys      (clk_sys),
    .RESET_N      (RESET_N),
    .pll_locked   (pll_locked),
    .sdram_ready  (sdram_ready),
    .rom_download (rom_download),
    .rom_valid    (rom_valid),
    .user_reset   (user_reset),
    .sdram_init   (sdram_init),
    .core_reset   (core_reset),
    .cpu_reset_n  (cpu_reset_n),
    .boot_state   (boot_state),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase plus "how long have we been here" ages, stepped once per clock edge.
  typedef struct packed {
    int   st;
    int   prev;
    int   stable;
    int   hold_age;
    int   run_age;
    int   prev_age;
    logic p1;
    logic p2;
    logic ur_prev;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic pll, logic rdy, logic dl,
                                        logic valid, logic ur);
    model_t r;
    logic   ls, uq;
    r = c;
    ls = c.p2;
    r.p2 = c.p1;
    r.p1 = pll;
    uq = ur && !c.ur_prev;
    r.ur_prev = ur;
    r.prev = c.st;
    r.prev_age = c.run_age;
    if (c.st != 0 && !ls) begin
      r.st = 0;
    end else begin
      case (c.st)
        0: begin
          r.stable = ls ? c.stable + 1 : 0;
          if (r.stable == 2 ** RB) r.st = 1;
        end
        1: if (rdy) r.st = 2;
        2: if (!dl && valid) begin r.st = 3; r.hold_age = 1; end
        default: begin
          if (dl) r.st = 2;
          else if (uq) begin r.st = 3; r.hold_age = 1; end
          else if (c.st == 3) begin
            if (c.hold_age == DLY + 1) begin r.st = 4; r.run_age = 1; end
            else r.hold_age = c.hold_age + 1;
          end else if (c.run_age < 1000) r.run_age = c.run_age + 1;
        end
      endcase
    end
    if (r.st != 0) r.stable = 0;
    return r;
  endfunction

  always @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) m <= '0;
    else m <= model_next(m, pll_locked, sdram_ready, rom_download, rom_valid, user_reset);
  end

  always @(negedge clk_sys) begin
    check_eq("boot_state", {29'd0, boot_state}, m.st);
    check_eq("core_reset", {31'd0, core_reset}, {31'd0, m.prev != 4});
    check_eq("busy", {31'd0, busy}, {31'd0, m.prev != 4});
    check_eq("cpu_reset_n", {31'd0, cpu_reset_n}, {31'd0, m.prev == 4 && m.prev_age >= LAG + 1});
    check_eq("sdram_init", {31'd0, sdram_init}, {31'd0, m.st == 1 && m.prev != 1});
    if (sdram_init === 1'b1) n_init++;
  end

  task automatic cyc(input int cnt = 1);
    repeat (cnt) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int w = 0;
    while (boot_state !== s && w < budget) begin
      cyc();
      w++;
    end
    if (boot_state !== s) check_eq(tag, {29'd0, boot_state}, {29'd0, s});
  endtask

  task automatic hold_len(output int len);
    len = 0;
    while (boot_state === 3'd3 && len < 200) begin
      len++;
      cyc();
    end
  endtask

  task automatic power_up(input logic rdy);
    RESET_N = 1'b0;
    pll_locked = 1'b1; sdram_ready = rdy; rom_valid = 1'b1;
    rom_download = 1'b0; user_reset = 1'b0;
    cyc(5);
    RESET_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: power-up
    power_up(1'b0);
    check_eq("rst_boot_state", {29'd0, boot_state}, 0);
    check_eq("rst_core_reset", {31'd0, core_reset}, 1);
    check_eq("rst_cpu_reset_n", {31'd0, cpu_reset_n}, 0);
    check_eq("rst_busy", {31'd0, busy}, 1);
    n_init = 0;
    cyc(25);
    sdram_ready = 1'b1;
    wait_state(3'd3, 100, "t1_reach_hold");
    hold_len(n);
    check_eq("t1_hold_len", n, DLY + 1);
    check_eq("t1_core_at_run_entry", {31'd0, core_reset}, 1);
    cyc();
    check_eq("t1_core_fall", {31'd0, core_reset}, 0);
    k = 0;
    while (cpu_reset_n !== 1'b1 && k < 50) begin cyc(); k++; end
    check_eq("t1_cpu_lag", k, LAG);
    check_eq("t1_busy", {31'd0, busy}, 0);
    check_eq("t1_init_pulses", n_init, 1);

    // 2: one-cycle lock glitch at lock_cnt=10
    power_up(1'b1);
    cyc(12);
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    k = 0;
    while (boot_state !== 3'd1 && k < 60) begin cyc(); k++; end
    check_eq("t2_relock_cycles", k, 2 ** RB + 2);
    check_eq("t2_init", {31'd0, sdram_init}, 1);

    // 3: download while running
    wait_state(3'd4, 100, "t3_reach_run");
    cyc(8);
    rom_download = 1'b1;
    cyc();
    check_eq("t3_rom", {29'd0, boot_state}, 2);
    cyc();
    check_eq("t3_core", {31'd0, core_reset}, 1);
    check_eq("t3_cpu", {31'd0, cpu_reset_n}, 0);
    cyc(48);
    rom_download = 1'b0;
    wait_state(3'd3, 5, "t3_hold");
    hold_len(n);
    check_eq("t3_hold_len", n, DLY + 1);
    check_eq("t3_run", {29'd0, boot_state}, 4);

    // 4: user reset held high
    cyc(8);
    user_reset = 1'b1;
    entries = 0;
    prev_bs = 4;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (boot_state === 3'd3 && prev_bs != 3) entries++;
      prev_bs = int'(boot_state);
    end
    check_eq("t4_hold_entries", entries, 1);
    check_eq("t4_run", {29'd0, boot_state}, 4);
    user_reset = 1'b0;

    // 5: lock loss, download and user-reset edge coincide
    cyc(3);
    pll_locked = 1'b0;
    cyc(2);
    rom_download = 1'b1;
    user_reset = 1'b1;
    cyc();
    check_eq("t5_lock", {29'd0, boot_state}, 0);
    n_init = 0;
    cyc(30);
    check_eq("t5_no_init", n_init, 0);
    rom_download = 1'b0;
    user_reset = 1'b0;
    pll_locked = 1'b1;
    wait_state(3'd1, 40, "t5_meminit");
    check_eq("t5_init", {31'd0, sdram_init}, 1);

    // 6: asynchronous reset mid-HOLD
    wait_state(3'd3, 50, "t6_hold");
    cyc(8);
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("t6_boot_state", {29'd0, boot_state}, 0);
    check_eq("t6_core_reset", {31'd0, core_reset}, 1);
    check_eq("t6_cpu_reset_n", {31'd0, cpu_reset_n}, 0);
    cyc(3);
    RESET_N = 1'b1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      pll_locked  = ($urandom_range(0, 299) != 0);
      sdram_ready = ($urandom_range(0, 9) != 0);
      rom_valid   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 59) == 0) rom_download = ~rom_download;
      if ($urandom_range(0, 39) == 0) user_reset = ~user_reset;
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
